// File: rtl/apb_reg_slave.sv
// APB3 completer with a small register bank.
//   idx 0      : CTRL    (rw, mirrored on ctrl_o)
//   idx 1      : STATUS  (ro, returns live status_i)
//   idx 2..N-1 : SCRATCH (rw)
// Byte address PADDR, register index = PADDR >> 2.
// Optional build macro APB_SLV_WAIT_EN: inserts WAIT_CYCLES wait states per
// transfer. Without it every transfer completes on its first access cycle.
//
// Completion (PREADY, PSLVERR, PRDATA) is decoded from the live APB inputs so
// that a zero-wait transfer can complete in the same cycle PENABLE rises. The
// FSM and the wait counter are registered, and all register-bank writes are
// committed on the rising edge that ends the completion cycle.
module apb_reg_slave #(
  parameter int PADDR_SIZE  = 16,
  parameter int PDATA_SIZE  = 32,
  parameter int NREGS       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic                    PWRITE,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [PDATA_SIZE-1:0]   ctrl_o,
  input  logic [PDATA_SIZE-1:0]   status_i
);

  localparam int NLANES = PDATA_SIZE / 8;
  localparam int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int AIDX_W = PADDR_SIZE - 2;

  // ST_ACCESS means an access phase is in progress past its first cycle,
  // i.e. the completer is holding the master in wait states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  logic [PDATA_SIZE-1:0] r_regs [NREGS];

`ifdef APB_SLV_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] r_count;
`endif

  logic              w_access;
  logic [AIDX_W-1:0] w_idx;
  logic [IDX_W-1:0]  w_sel;
  logic              w_is_status;
  logic              w_err;
  logic              w_ready;
  logic              w_commit;
  logic [PDATA_SIZE-1:0] w_rdata;

  assign w_access    = PSEL & PENABLE;
  assign w_idx       = PADDR[PADDR_SIZE-1:2];
  assign w_sel       = w_idx[IDX_W-1:0];
  assign w_is_status = (w_idx == AIDX_W'(1));

  // Misaligned, out of range, or a write to the read-only STATUS word.
  assign w_err = (PADDR[1:0] != 2'b00)
               | (w_idx >= AIDX_W'(NREGS))
               | (PWRITE & w_is_status);

  // The counter is 0 on the first access cycle, so it counts access cycles
  // already spent; completion is when it reaches WAIT_CYCLES. Reset forces
  // completion low so a transfer caught by reset never reports done.
`ifdef APB_SLV_WAIT_EN
  assign w_ready = PRESETn & w_access & (r_count == CNT_W'(WAIT_CYCLES));
`else
  assign w_ready = PRESETn & w_access;
`endif

  assign w_commit = w_ready & PWRITE & ~w_err;
  assign w_rdata  = w_is_status ? status_i : r_regs[w_sel];

  // Response bus is quiet (all zero) outside the completion cycle.
  assign PREADY  = w_ready;
  assign PSLVERR = w_ready & w_err;
  assign PRDATA  = (w_ready & ~w_err & ~PWRITE) ? w_rdata : '0;
  assign ctrl_o  = r_regs[0];

  // Transfer FSM: track wait states and drop back to idle on completion or
  // when the master abandons the access phase.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
`ifdef APB_SLV_WAIT_EN
      r_count <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access && !w_ready) begin
            r_state <= ST_ACCESS;
`ifdef APB_SLV_WAIT_EN
            r_count <= CNT_W'(1);
`endif
          end
        end
        ST_ACCESS: begin
          if (!w_access || w_ready) begin
            r_state <= ST_IDLE;
`ifdef APB_SLV_WAIT_EN
            r_count <= '0;
`endif
          end else begin
`ifdef APB_SLV_WAIT_EN
            r_count <= r_count + CNT_W'(1);
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
`ifdef APB_SLV_WAIT_EN
          r_count <= '0;
`endif
        end
      endcase
    end
  end

  // Register bank: byte-lane write on a committing completion; STATUS is
  // never written because writes to it are always flagged as errors.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      for (int b = 0; b < NLANES; b++) begin
        if (PSTRB[b]) begin
          r_regs[w_sel][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: the driver pushes the expected response
// of each transfer, a negedge monitor pops and compares on every PREADY.
module tb_apb_reg_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [15:0] PADDR = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] ctrl_o;
  logic [31:0] status_i = '0;

  int total = 0;
  int bad   = 0;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    string       name;
  } exp_t;

  exp_t sb[$];

  apb_reg_slave #(
    .PADDR_SIZE (16),
    .PDATA_SIZE (32),
    .NREGS      (8),
    .WAIT_CYCLES(2)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PSTRB   (PSTRB),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .ctrl_o  (ctrl_o),
    .status_i(status_i)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest expected response;
  // outside completion the response bus must stay at zero.
  always @(negedge PCLK) begin : monitor
    exp_t e;
    if (PREADY === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pready: got PREADY=1 with no transfer pending");
      end else begin
        e = sb.pop_front();
        check({e.name, "_slverr"}, {31'b0, PSLVERR}, {31'b0, e.err});
        if (e.chk_data) check({e.name, "_prdata"}, PRDATA, e.data);
        $display("xfer %-12s addr=0x%04h wr=%0b slverr=%0b prdata=0x%08h",
                 e.name, PADDR, PWRITE, PSLVERR, PRDATA);
      end
    end else begin
      check("idle_slverr", {31'b0, PSLVERR}, 32'h0);
      check("idle_prdata", PRDATA, 32'h0);
    end
  end

  // One APB transfer; returns on the negedge of the completion cycle so the
  // next call can start its setup phase directly (back-to-back).
  task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] exp_data,
                     input logic exp_err, input string name);
    int n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    sb.push_back('{exp_data, exp_err, (!wr || exp_err), name});
    n = 1;
    @(negedge PCLK);
    while (PREADY !== 1'b1 && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    if (PREADY !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no PREADY after %0d cycles, expected PREADY=1", name, n);
    end else begin
      check({name, "_lat"}, n, EXP_LAT);
    end
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench to end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst0_pready",  {31'b0, PREADY},  32'h0);
    check("rst0_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst0_prdata",  PRDATA, 32'h0);
    check("rst0_ctrl",    ctrl_o, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Prime CTRL and a scratch word so reset has something to clear.
    apb(1'b1, 16'h0000, 32'h0000_0005, 4'hF, 32'h0, 1'b0, "wr_ctrl5");
    check("ctrl_same_cycle", ctrl_o, 32'h0);
    idle();
    @(negedge PCLK);
    check("ctrl_next_cycle", ctrl_o, 32'h0000_0005);
    apb(1'b1, 16'h0008, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "wr_s2_prime");
    idle();

    // Reset lands on the first access cycle of a write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0008;
    PWDATA = 32'hAAAA_5555; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PRESETn = 1'b0;
    @(negedge PCLK);
    check("rst_pready",  {31'b0, PREADY},  32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_prdata",  PRDATA, 32'h0);
    check("rst_ctrl",    ctrl_o, 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb(1'b0, 16'h0008, 32'h0, 4'h0, 32'h0, 1'b0, "rd_s2_aborted");
    apb(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, 1'b0, "rd_ctrl_rst");
    idle();

    // Full write / read.
    apb(1'b1, 16'h0008, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "wr_s2_full");
    idle();
    apb(1'b0, 16'h0008, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, "rd_s2_full");
    idle();

    // Byte strobes: lanes 0 and 2 only.
    apb(1'b1, 16'h0008, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, "wr_s2_strb");
    idle();
    apb(1'b0, 16'h0008, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, "rd_s2_strb");
    idle();

    // Error responses and no side effects.
    status_i = 32'h0000_0077;
    apb(1'b1, 16'h0004, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_status_err");
    idle();
    apb(1'b0, 16'h0002, 32'h0, 4'h0, 32'h0, 1'b1, "rd_misal_err");
    idle();
    apb(1'b0, 16'h0020, 32'h0, 4'h0, 32'h0, 1'b1, "rd_range_err");
    idle();
    apb(1'b1, 16'h000A, 32'h9999_9999, 4'hF, 32'h0, 1'b1, "wr_misal_err");
    idle();
    apb(1'b1, 16'h0020, 32'h9999_9999, 4'hF, 32'h0, 1'b1, "wr_range_err");
    idle();
    apb(1'b0, 16'h0008, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, "rd_s2_kept");
    idle();
    apb(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, 1'b0, "rd_ctrl_kept");
    idle();

    // STATUS read and CTRL update timing.
    status_i = 32'h0000_A5A5;
    apb(1'b0, 16'h0004, 32'h0, 4'h0, 32'h0000_A5A5, 1'b0, "rd_status");
    idle();
    apb(1'b1, 16'h0000, 32'h0000_0003, 4'hF, 32'h0, 1'b0, "wr_ctrl3");
    check("ctrl3_same_cycle", ctrl_o, 32'h0);
    idle();
    @(negedge PCLK);
    check("ctrl3_next_cycle", ctrl_o, 32'h0000_0003);

    // Top scratch index, then back-to-back reads with no idle cycle.
    apb(1'b1, 16'h001C, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "wr_s7");
    status_i = 32'h1234_0000;
    apb(1'b0, 16'h0008, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, "b2b_rd_s2");
    apb(1'b0, 16'h001C, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "b2b_rd_s7");
    apb(1'b0, 16'h0004, 32'h0, 4'h0, 32'h1234_0000, 1'b0, "b2b_rd_stat");
    apb(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0000_0003, 1'b0, "b2b_rd_ctrl");
    idle();

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("sb_drained", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
